// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: STAGES registered chunks with ripple carry and valid/ready backpressure.
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];

  logic [STAGES-1:0] w_take;
  logic [STAGES-1:0] w_nvalid;
  logic [STAGES-1:0] w_ncarry;
  logic [WIDTH-1:0]  w_nsum [STAGES];
  logic [WIDTH-1:0]  w_nopa [STAGES];
  logic [WIDTH-1:0]  w_nopb [STAGES];
  logic              w_in_xfer;

  // A stage can load when it is empty or its content moves on; walk from the output back.
  always_comb begin : take_chain
    logic l_down;
    l_down = out_ready;
    w_take = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_take[LAST-i] = !r_valid[LAST-i] | l_down;
      l_down         = w_take[LAST-i];
    end
  end

  assign in_ready  = !rst & w_take[0];
  assign w_in_xfer = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_ns;
    logic             w_ci;
    logic             w_vin;
    logic [CW:0]      w_add;

    if (k == 0) begin : g_head
      assign w_opa  = a;
      assign w_opb  = b;
      assign w_base = '0;
      assign w_ci   = cin;
      assign w_vin  = w_in_xfer;
    end else begin : g_body
      assign w_opa  = r_a[k-1];
      assign w_opb  = r_b[k-1];
      assign w_base = r_sum[k-1];
      assign w_ci   = r_carry[k-1];
      assign w_vin  = r_valid[k-1];
    end

    assign w_add = {1'b0, w_opa[k*CW +: CW]} + {1'b0, w_opb[k*CW +: CW]} + {{CW{1'b0}}, w_ci};

    // Lower chunks come along from upstream so the whole word belongs to one transaction.
    always_comb begin
      w_ns              = w_base;
      w_ns[k*CW +: CW]  = w_add[CW-1:0];
    end

    assign w_nsum[k]   = w_ns;
    assign w_nopa[k]   = w_opa;
    assign w_nopb[k]   = w_opb;
    assign w_ncarry[k] = w_add[CW];
    assign w_nvalid[k] = w_vin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_carry <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_sum[i] <= '0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (w_take[i]) begin
          r_valid[i] <= w_nvalid[i];
          // Data only moves with a real transaction, so idle outputs stay put.
          if (w_nvalid[i]) begin
            r_sum[i]   <= w_nsum[i];
            r_carry[i] <= w_ncarry[i];
            r_a[i]     <= w_nopa[i];
            r_b[i]     <= w_nopb[i];
          end
        end
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_carry[LAST];

`ifdef ADDER_OVF_EN
  logic r_ovf;
  logic w_novf;

  assign w_novf = (w_nopa[LAST][WIDTH-1] == w_nopb[LAST][WIDTH-1]) &
                  (w_nsum[LAST][WIDTH-1] != w_nopa[LAST][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_take[LAST] && w_nvalid[LAST]) begin
      r_ovf <= w_novf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (W=16, S=4): random and directed stimulus vs. an arithmetic model.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;
`ifdef ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  typedef struct packed {
    logic         o;
    logic         c;
    logic [W-1:0] s;
  } res_t;

  res_t q[$];
  res_t e_pop;
  res_t prev_out;
  logic prev_stall = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_out    = 0;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int unsigned t;
    res_t        r;
    t   = 32'(x) + 32'(y) + 32'(ci);
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = OVF_EN && (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, got, exp);
    end
  endtask

  // Handshakes are stable between negedge and the next posedge, so they are observed here.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 32'({ovf, cout, sum}), 32'(prev_out));
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e_pop = q.pop_front();
          check("result", 32'({ovf, cout, sum}), 32'(e_pop));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, cout, sum};
      if (in_valid && in_ready) begin
        n_acc++;
        q.push_back(model(a, b, cin));
      end
    end
  end

  task automatic cyc(output bit took);
    @(negedge clk);
    took = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    bit t;
    int n;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    n = 0;
    do begin
      cyc(t);
      n++;
    end while (!t && n < 50);
    if (!t) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit t;
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      cyc(t);
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit t;
    int lat;
    int stalls;
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;

    // 1. reset / idle
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 2. single add, latency
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    cyc(t);
    check("single_accept", 32'(t), 32'd1);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'(S));
    check("single_sum", 32'(sum), 32'h0100);
    @(posedge clk); #1;
    drain();

    // 3. carry chain / overflow corners
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // 4. streaming at full rate
    out_ready = 1'b1; stalls = 0; base = n_out;
    rand_ops();
    in_valid = 1'b1;
    repeat (100) begin
      cyc(t);
      if (!t) stalls++;
      rand_ops();
    end
    in_valid = 1'b0;
    check("stream_no_stall", 32'(stalls), 32'd0);
    repeat (2) cyc(t);
    @(negedge clk); #1;
    check("stream_one_left", 32'(q.size()), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("stream_all_out", 32'(q.size()), 32'd0);
    check("stream_count", 32'(n_out - base), 32'd100);
    @(posedge clk); #1;

    // 5. backpressure: pipeline fills to S entries then blocks
    out_ready = 1'b0; base = n_acc;
    rand_ops();
    in_valid = 1'b1;
    repeat (10) begin
      cyc(t);
      if (t) rand_ops();
    end
    check("bp_accepts", 32'(n_acc - base), 32'(S));
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    drain();

    // random valid/ready toggling
    rand_ops();
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cyc(t);
      if (t) rand_ops();
    end
    drain();

    // 6. reset with three in flight
    out_ready = 1'b0; base = n_acc;
    repeat (3) begin
      rand_ops();
      send(a, b, cin);
    end
    check("flight_accepts", 32'(n_acc - base), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1; base = n_out;
    repeat (10) cyc(t);
    check("discarded_none_out", 32'(n_out - base), 32'd0);
    send(16'h1234, 16'h4321, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
